// File: rtl/tricolor_mode_sequencer.sv
// Tri-colour LED mode controller: debounces NEXT/AUTO keys, runs the colour mode FSM
// (manual step or timed auto-cycle) and drives the registered LED bank.
module tricolor_mode_sequencer #(
    parameter int DEBOUNCE_CYC = 50_000,
    parameter int STEP_CYC     = 25_000_000
) (
    input  logic       Sys_CLK,
    input  logic       Sys_RST,
    input  logic [1:0] Key,
    output logic [3:0] LED,
    output logic [2:0] mode,
    output logic       auto_en
);

    localparam int DB_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam int DW_W = (STEP_CYC > 1) ? $clog2(STEP_CYC) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [DW_W-1:0] DW_LAST = DW_W'(STEP_CYC - 1);

    localparam logic [2:0] MODE_OFF   = 3'd0;
    localparam logic [2:0] MODE_RED   = 3'd1;
    localparam logic [2:0] MODE_GREEN = 3'd2;
    localparam logic [2:0] MODE_BLUE  = 3'd3;
    localparam logic [2:0] MODE_WHITE = 3'd4;

    logic [1:0]      key_ev;
    logic [2:0]      mode_reg, mode_next, mode_base;
    logic            auto_en_reg, auto_en_next;
    logic [DW_W-1:0] dwell_reg, dwell_next;
    logic [3:0]      led_reg;

    // Per key: 2-flop synchroniser, debounce counter, rising-edge event pulse.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_key
            logic            sync1_reg, sync2_reg, deb_reg, deb_d_reg, ev_reg;
            logic [DB_W-1:0] cnt_reg;

            always_ff @(posedge Sys_CLK) begin
                if (!Sys_RST) begin
                    sync1_reg <= 1'b0;
                    sync2_reg <= 1'b0;
                    deb_reg   <= 1'b0;
                    deb_d_reg <= 1'b0;
                    ev_reg    <= 1'b0;
                    cnt_reg   <= '0;
                end else begin
                    sync1_reg <= Key[gi];
                    sync2_reg <= sync1_reg;
                    if (sync2_reg != deb_reg) begin
                        if (cnt_reg == DB_LAST) begin
                            deb_reg <= sync2_reg;
                            cnt_reg <= '0;
                        end else begin
                            cnt_reg <= cnt_reg + DB_W'(1);
                        end
                    end else begin
                        cnt_reg <= '0;
                    end
                    deb_d_reg <= deb_reg;
                    ev_reg    <= deb_reg & ~deb_d_reg;
                end
            end

            assign key_ev[gi] = ev_reg;
        end
    endgenerate

    function automatic logic [2:0] next_manual(input logic [2:0] m);
        case (m)
            MODE_OFF:   return MODE_RED;
            MODE_RED:   return MODE_GREEN;
            MODE_GREEN: return MODE_BLUE;
            MODE_BLUE:  return MODE_WHITE;
            default:    return MODE_OFF;
        endcase
    endfunction

    function automatic logic [2:0] next_auto(input logic [2:0] m);
        case (m)
            MODE_RED:   return MODE_GREEN;
            MODE_GREEN: return MODE_BLUE;
            MODE_BLUE:  return MODE_WHITE;
            default:    return MODE_RED;
        endcase
    endfunction

    // AUTO toggle resolves first; NEXT then advances from the resulting mode.
    always_comb begin
        auto_en_next = auto_en_reg ^ key_ev[1];
        dwell_next   = dwell_reg;
        mode_base    = mode_reg;
        if (key_ev[1] && !auto_en_reg && mode_reg == MODE_OFF)
            mode_base = MODE_RED;
        mode_next = mode_base;

        if (mode_reg > MODE_WHITE) begin
            mode_next = MODE_OFF;
        end else if (key_ev[0]) begin
            mode_next  = next_manual(mode_base);
            dwell_next = '0;
        end else if (auto_en_reg && !key_ev[1]) begin
            if (dwell_reg == DW_LAST) begin
                dwell_next = '0;
                mode_next  = next_auto(mode_reg);
            end else begin
                dwell_next = dwell_reg + DW_W'(1);
            end
        end

        // Dwell rests at zero while auto is off, so enabling starts a fresh interval.
        if (!auto_en_next)
            dwell_next = '0;
    end

    always_ff @(posedge Sys_CLK) begin
        if (!Sys_RST) begin
            mode_reg    <= MODE_OFF;
            auto_en_reg <= 1'b0;
            dwell_reg   <= '0;
            led_reg     <= 4'b0000;
        end else begin
            mode_reg    <= mode_next;
            auto_en_reg <= auto_en_next;
            dwell_reg   <= dwell_next;
            led_reg[3]  <= auto_en_reg;
            case (mode_reg)
                MODE_RED:   led_reg[2:0] <= 3'b001;
                MODE_GREEN: led_reg[2:0] <= 3'b010;
                MODE_BLUE:  led_reg[2:0] <= 3'b100;
                MODE_WHITE: led_reg[2:0] <= 3'b111;
                default:    led_reg[2:0] <= 3'b000;
            endcase
        end
    end

    assign LED     = led_reg;
    assign mode    = mode_reg;
    assign auto_en = auto_en_reg;

endmodule

// File: tb/tb_tricolor_mode_sequencer.sv
// Bench for tricolor_mode_sequencer: directed scenarios plus randomized keys checked
// against a cycle-level behavioural model of the key, mode and LED rules.
module tb_tricolor_mode_sequencer;

    localparam int DB = 4;
    localparam int ST = 10;

    logic       Sys_CLK = 1'b0;
    logic       Sys_RST;
    logic [1:0] Key;
    logic [3:0] LED;
    logic [2:0] mode;
    logic       auto_en;

    int checks   = 0;
    int failures = 0;

    tricolor_mode_sequencer #(
        .DEBOUNCE_CYC(DB),
        .STEP_CYC    (ST)
    ) dut (
        .Sys_CLK(Sys_CLK),
        .Sys_RST(Sys_RST),
        .Key    (Key),
        .LED    (LED),
        .mode   (mode),
        .auto_en(auto_en)
    );

    always #5 Sys_CLK = ~Sys_CLK;

    // Reference model state
    int m_s1[2], m_s2[2], m_db[2], m_run[2], m_prev[2], m_ev[2];
    int m_mode, m_auto, m_dwell;
    logic [3:0] m_led;

    function automatic logic [2:0] colour_bits(input int md);
        logic [2:0] one;
        one = 3'b001;
        if (md == 0) return 3'b000;
        if (md == 4) return 3'b111;
        return one << (md - 1);
    endfunction

    task automatic model_step();
        int a_ev, x_ev, nm, na, nd;
        if (!Sys_RST) begin
            for (int k = 0; k < 2; k++) begin
                m_s1[k] = 0; m_s2[k] = 0; m_db[k] = 0; m_run[k] = 0; m_prev[k] = 0; m_ev[k] = 0;
            end
            m_mode = 0; m_auto = 0; m_dwell = 0; m_led = 4'b0000;
        end else begin
            m_led = {(m_auto != 0), colour_bits(m_mode)};
            x_ev = m_ev[0];
            a_ev = m_ev[1];
            na = m_auto ^ a_ev;
            nm = m_mode;
            nd = m_dwell;
            if (a_ev != 0 && m_auto == 0) begin
                nd = 0;
                if (nm == 0) nm = 1;
            end
            if (x_ev != 0) begin
                nm = (nm + 1) % 5;
                nd = 0;
            end else if (m_auto != 0 && a_ev == 0) begin
                if (nd == ST - 1) begin
                    nd = 0;
                    nm = (nm % 4) + 1;
                end else begin
                    nd = nd + 1;
                end
            end
            m_mode = nm; m_auto = na; m_dwell = nd;
            for (int k = 0; k < 2; k++) begin
                m_ev[k]   = (m_db[k] != 0 && m_prev[k] == 0) ? 1 : 0;
                m_prev[k] = m_db[k];
                // a new level is accepted after it has differed for DB consecutive cycles
                if (m_s2[k] != m_db[k]) begin
                    m_run[k] = m_run[k] + 1;
                    if (m_run[k] == DB) begin
                        m_db[k]  = m_s2[k];
                        m_run[k] = 0;
                    end
                end else begin
                    m_run[k] = 0;
                end
                m_s2[k] = m_s1[k];
                m_s1[k] = int'(Key[k]);
            end
        end
    endtask

    task automatic tick();
        @(posedge Sys_CLK);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        Sys_RST = 1'b0;
        Key = 2'b00;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (LED !== 4'b0000 || mode !== 3'd0 || auto_en !== 1'b0) begin
                failures++;
                $display("FAIL reset_hold cyc=%0d: LED=%b mode=%0d auto_en=%b, required 0000/0/0", i, LED, mode, auto_en);
            end
        end
        Sys_RST = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (LED !== 4'b0000 || mode !== 3'd0 || auto_en !== 1'b0) begin
                failures++;
                $display("FAIL reset_release cyc=%0d: LED=%b mode=%0d auto_en=%b, required 0000/0/0", i, LED, mode, auto_en);
            end
        end
        $display("reset: LED=%b mode=%0d auto_en=%b", LED, mode, auto_en);
    endtask

    task automatic test_next_press();
        int exp_led[5];
        int exp_mode[5];
        int prev_led, prev_mode;
        exp_led  = '{1, 2, 4, 7, 0};
        exp_mode = '{1, 2, 3, 4, 0};
        prev_led = 0;
        prev_mode = 0;
        for (int p = 0; p < 5; p++) begin
            Key[0] = 1'b1;
            for (int t = 0; t < 20; t++) begin
                tick();
                if (t == 6) begin
                    checks++;
                    if (mode !== 3'(prev_mode)) begin
                        failures++;
                        $display("FAIL next_early p=%0d: mode=%0d required %0d", p, mode, prev_mode);
                    end
                end
                if (t == 7) begin
                    checks++;
                    if (mode !== 3'(exp_mode[p]) || LED[2:0] !== 3'(prev_led)) begin
                        failures++;
                        $display("FAIL next_mode p=%0d: mode=%0d LED=%b required mode=%0d LED=%b",
                                 p, mode, LED[2:0], exp_mode[p], 3'(prev_led));
                    end
                end
                if (t == 8) begin
                    checks++;
                    if (LED !== {1'b0, 3'(exp_led[p])}) begin
                        failures++;
                        $display("FAIL next_led p=%0d: LED=%b required 0%b", p, LED, 3'(exp_led[p]));
                    end
                end
            end
            Key[0] = 1'b0;
            for (int t = 0; t < 20; t++) tick();
            $display("press %0d: mode=%0d LED=%b", p, mode, LED);
            prev_led = exp_led[p];
            prev_mode = exp_mode[p];
        end
    endtask

    task automatic test_bounce();
        Key[0] = 1'b1; tick();
        Key[0] = 1'b0; tick();
        Key[0] = 1'b1; tick();
        Key[0] = 1'b0;
        for (int t = 0; t < 20; t++) tick();
        checks++;
        if (mode !== 3'd0 || LED !== 4'b0000) begin
            failures++;
            $display("FAIL bounce: mode=%0d LED=%b required 0/0000", mode, LED);
        end
        Key[0] = 1'b1;
        for (int t = 0; t < 3; t++) tick();
        Key[0] = 1'b0;
        for (int t = 0; t < 20; t++) tick();
        checks++;
        if (mode !== 3'd0 || LED !== 4'b0000) begin
            failures++;
            $display("FAIL short_pulse: mode=%0d LED=%b required 0/0000", mode, LED);
        end
        $display("bounce: mode=%0d LED=%b", mode, LED);
    endtask

    task automatic test_auto();
        int step_t[5];
        int step_m[5];
        step_t = '{16, 17, 27, 37, 47};
        step_m = '{1, 2, 3, 4, 1};
        for (int t = 0; t < 100; t++) begin
            if (t == 0)  Key[1] = 1'b1;
            if (t == 20) Key[1] = 1'b0;
            if (t == 48) Key[1] = 1'b1;
            if (t == 68) Key[1] = 1'b0;
            tick();
            if (t == 6 || t == 7) begin
                checks++;
                if (auto_en !== (t == 7) || (t == 7 && mode !== 3'd1)) begin
                    failures++;
                    $display("FAIL auto_enable t=%0d: auto_en=%b mode=%0d required %b/%0d", t, auto_en, mode, t == 7, (t == 7) ? 1 : 0);
                end
            end
            if (t == 8) begin
                checks++;
                if (LED !== 4'b1001) begin
                    failures++;
                    $display("FAIL auto_led: LED=%b required 1001", LED);
                end
            end
            for (int s = 0; s < 5; s++) begin
                if (t == step_t[s]) begin
                    checks++;
                    if (mode !== 3'(step_m[s])) begin
                        failures++;
                        $display("FAIL auto_step t=%0d: mode=%0d required %0d", t, mode, step_m[s]);
                    end
                end
            end
            if (t == 54 || t == 55) begin
                checks++;
                if (auto_en !== (t == 54) || mode !== 3'd1) begin
                    failures++;
                    $display("FAIL auto_disable t=%0d: auto_en=%b mode=%0d required %b/1", t, auto_en, mode, t == 54);
                end
            end
            if (t == 56 || t == 99) begin
                checks++;
                if (LED !== 4'b0001 || mode !== 3'd1 || auto_en !== 1'b0) begin
                    failures++;
                    $display("FAIL auto_frozen t=%0d: LED=%b mode=%0d auto_en=%b required 0001/1/0", t, LED, mode, auto_en);
                end
            end
        end
        $display("auto: mode=%0d LED=%b auto_en=%b", mode, LED, auto_en);
    endtask

    task automatic test_simultaneous();
        int chk_t[7];
        int chk_m[7];
        chk_t = '{16, 17, 27, 36, 37, 46, 47};
        chk_m = '{2, 3, 4, 4, 0, 0, 1};
        Sys_RST = 1'b0;
        for (int t = 0; t < 3; t++) tick();
        Sys_RST = 1'b1;
        for (int t = 0; t < 3; t++) tick();
        for (int t = 0; t < 60; t++) begin
            if (t == 0)  Key = 2'b11;
            if (t == 10) Key[0] = 1'b0;
            if (t == 20) Key[1] = 1'b0;
            if (t == 30) Key[0] = 1'b1;
            if (t == 40) Key[0] = 1'b0;
            tick();
            if (t == 7) begin
                checks++;
                if (auto_en !== 1'b1 || mode !== 3'd2) begin
                    failures++;
                    $display("FAIL simul_events: auto_en=%b mode=%0d required 1/2", auto_en, mode);
                end
            end
            if (t == 8) begin
                checks++;
                if (LED !== 4'b1010) begin
                    failures++;
                    $display("FAIL simul_led: LED=%b required 1010", LED);
                end
            end
            for (int s = 0; s < 7; s++) begin
                if (t == chk_t[s]) begin
                    checks++;
                    if (mode !== 3'(chk_m[s])) begin
                        failures++;
                        $display("FAIL simul_step t=%0d: mode=%0d required %0d", t, mode, chk_m[s]);
                    end
                end
            end
        end
        $display("simultaneous: mode=%0d LED=%b auto_en=%b", mode, LED, auto_en);
    endtask

    task automatic test_reset_mid();
        Key = 2'b01;
        for (int t = 0; t < 60; t++) begin
            Sys_RST = (t >= 4 && t <= 6) ? 1'b0 : 1'b1;
            tick();
            if (t >= 4 && t <= 6) begin
                checks++;
                if (LED !== 4'b0000 || mode !== 3'd0 || auto_en !== 1'b0) begin
                    failures++;
                    $display("FAIL mid_reset t=%0d: LED=%b mode=%0d auto_en=%b required 0000/0/0", t, LED, mode, auto_en);
                end
            end
            if (t == 13 || t == 14) begin
                checks++;
                if (mode !== ((t == 14) ? 3'd1 : 3'd0)) begin
                    failures++;
                    $display("FAIL held_key t=%0d: mode=%0d required %0d", t, mode, (t == 14) ? 1 : 0);
                end
            end
            if (t == 15 || t == 59) begin
                checks++;
                if (LED !== 4'b0001 || mode !== 3'd1 || auto_en !== 1'b0) begin
                    failures++;
                    $display("FAIL held_once t=%0d: LED=%b mode=%0d auto_en=%b required 0001/1/0", t, LED, mode, auto_en);
                end
            end
        end
        Key = 2'b00;
        for (int t = 0; t < 10; t++) tick();
        $display("reset_mid: mode=%0d LED=%b auto_en=%b", mode, LED, auto_en);
    endtask

    task automatic test_random();
        int hold;
        Sys_RST = 1'b0;
        Key = 2'b00;
        tick(); tick();
        Sys_RST = 1'b1;
        hold = 0;
        for (int t = 0; t < 1500; t++) begin
            if (hold == 0) begin
                Key  = 2'($urandom_range(0, 3));
                hold = $urandom_range(1, 20);
            end
            hold--;
            Sys_RST = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
            tick();
            checks++;
            if (mode !== m_mode[2:0] || auto_en !== (m_auto != 0) || LED !== m_led) begin
                failures++;
                $display("FAIL random t=%0d: mode=%0d auto_en=%b LED=%b required %0d/%b/%b",
                         t, mode, auto_en, LED, m_mode, m_auto != 0, m_led);
            end
        end
        $display("random: final mode=%0d LED=%b auto_en=%b", mode, LED, auto_en);
    endtask

    initial begin
        Sys_RST = 1'b0;
        Key = 2'b00;
        test_reset();
        test_next_press();
        test_bounce();
        test_auto();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
